// File: rtl/microcode_pipeline_pkg.sv
// Shared types and microword field layout for the microcode pipeline.
// Field positions are fixed; the halt bit is always the top data bit.
package microcode_pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int S_LSB   = 0;
  localparam int S_W     = 2;
  localparam int FE_BIT  = 2;
  localparam int PUP_BIT = 3;
  localparam int D_LSB   = 4;

  localparam logic [63:0] NOP_WORD = '0;

  function automatic int halt_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/microcode_pipeline_ucode_store.sv
// Control store: one synchronous write port, one asynchronous read port
// with write-through bypass when the write address matches the read address.
module ucode_store #(
  parameter int AW = 12,
  parameter int SW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [SW-1:0] wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [SW-1:0] rd_o
);

  logic [SW-1:0] mem_q [2**AW];

  // Contents survive reset; reset only blocks a write landing while it is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (!rst_i && we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_o = (we_i && (wa_i == ra_i)) ? wd_i : mem_q[ra_i];

endmodule

// File: rtl/microcode_pipeline.sv
// Microcode pipeline register, control store and IDLE/FETCH/HALT sequencing FSM.
// Build option UCODE_PARITY_EN adds an even-parity bit per word and a sticky err_o.
module microcode_pipeline
  import microcode_pipeline_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          cp_i,
  input  logic          rst_i,
  input  logic [AW-1:0] y_i,
  input  logic          hold_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] mw_o,
  output logic [1:0]    s_o,
  output logic          fe_o,
  output logic          pup_o,
  output logic [AW-1:0] d_o,
  output logic          zero_o,
  output logic          run_o
`ifdef UCODE_PARITY_EN
  ,
  output logic          err_o
`endif
);

`ifdef UCODE_PARITY_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif
  localparam int HALT_BIT = halt_bit(DW);

  state_e        state_q;
  logic [DW-1:0] mw_q;
  logic          zero_q;
  logic          run_q;
  logic [SW-1:0] wd_ext;
  logic [SW-1:0] rd_ext;
  logic [DW-1:0] fetch_word;
  logic          parity_bad;

`ifdef UCODE_PARITY_EN
  logic err_q;
  assign wd_ext     = {^wd_i, wd_i};
  assign parity_bad = ^rd_ext;
`else
  assign wd_ext     = wd_i;
  assign parity_bad = 1'b0;
`endif
  assign fetch_word = rd_ext[DW-1:0];

  ucode_store #(
    .AW(AW),
    .SW(SW)
  ) u_store (
    .clk_i(cp_i),
    .rst_i(rst_i),
    .we_i (we_i),
    .wa_i (wa_i),
    .wd_i (wd_ext),
    .ra_i (y_i),
    .rd_o (rd_ext)
  );

  always_ff @(posedge cp_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mw_q    <= '0;
      zero_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef UCODE_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else if (!hold_i) begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          mw_q    <= NOP_WORD[DW-1:0];
          zero_q  <= 1'b1;
          run_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (parity_bad) begin
            // A corrupt word must never reach the sequencer; park on NOP.
            mw_q    <= NOP_WORD[DW-1:0];
            state_q <= ST_HALT;
            run_q   <= 1'b0;
`ifdef UCODE_PARITY_EN
            err_q   <= 1'b1;
`endif
          end else begin
            mw_q <= fetch_word;
            if (fetch_word[HALT_BIT]) begin
              state_q <= ST_HALT;
              run_q   <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
          mw_q    <= NOP_WORD[DW-1:0];
          zero_q  <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mw_o   = mw_q;
  assign s_o    = mw_q[S_LSB +: S_W];
  assign fe_o   = mw_q[FE_BIT];
  assign pup_o  = mw_q[PUP_BIT];
  assign d_o    = mw_q[D_LSB +: AW];
  assign zero_o = zero_q;
  assign run_o  = run_q;
`ifdef UCODE_PARITY_EN
  assign err_o  = err_q;
`endif

endmodule

// File: tb/tb_microcode_pipeline.sv
// Directed self-checking bench for microcode_pipeline (default AW=12, DW=32).
// Parity checks are compiled in when UCODE_PARITY_EN is defined.
module tb_microcode_pipeline;

  logic        cp, rst, hold, we;
  logic [11:0] y, wa, d;
  logic [31:0] wd, mw;
  logic [1:0]  s;
  logic        fe, pup, zero, run;
`ifdef UCODE_PARITY_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  microcode_pipeline #(.AW(12), .DW(32)) dut (
    .cp_i  (cp),
    .rst_i (rst),
    .y_i   (y),
    .hold_i(hold),
    .we_i  (we),
    .wa_i  (wa),
    .wd_i  (wd),
    .mw_o  (mw),
    .s_o   (s),
    .fe_o  (fe),
    .pup_o (pup),
    .d_o   (d),
    .zero_o(zero),
    .run_o (run)
`ifdef UCODE_PARITY_EN
    ,
    .err_o (err)
`endif
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    n_checks++; if (mw !== 32'h0) begin n_fail++; $display("FAIL %s_mw got %h exp 00000000", tag, mw); end
    n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL %s_run got %b exp 0", tag, run); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL %s_zero got %b exp 0", tag, zero); end
    n_checks++; if ({s, fe, pup, d} !== 16'h0) begin n_fail++; $display("FAIL %s_fields got %h exp 0000", tag, {s, fe, pup, d}); end
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b1; we = 1'b0; y = '0; wa = '0; wd = '0;
    #12;
    chk_idle_outputs("reset");
`ifdef UCODE_PARITY_EN
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
`endif
  endtask

  // Writes performed while held in IDLE after reset release.
  task automatic preload();
    logic [11:0] addrs [9] = '{12'h000, 12'h005, 12'h006, 12'h007, 12'h008,
                               12'hFFF, 12'h030, 12'h300, 12'h301};
    logic [31:0] datas [9] = '{32'h0000_0000, 32'h0000_0123, 32'h0000_0456,
                               32'h0000_0789, 32'h0000_0ABC, 32'h0000_0F0E,
                               32'h0000_0303, 32'h8000_0000, 32'h0000_0111};
    @(negedge cp);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; wa = addrs[i]; wd = datas[i];
      tick();
    end
    we = 1'b0;
    chk_idle_outputs("held_idle");
  endtask

  task automatic test_idle();
    hold = 1'b0; y = 12'h000;
    #1;
    chk_idle_outputs("idle");
    tick();
    n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL idle_exit_run got %b exp 1", run); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL idle_exit_zero got %b exp 1", zero); end
    n_checks++; if (mw !== 32'h0) begin n_fail++; $display("FAIL idle_exit_mw got %h exp 00000000", mw); end
  endtask

  task automatic test_fetch();
    logic [11:0] ys  [5] = '{12'h005, 12'h006, 12'h007, 12'hFFF, 12'h000};
    logic [31:0] emw [5] = '{32'h123, 32'h456, 32'h789, 32'hF0E, 32'h0};
    logic [15:0] efl [5] = '{{2'b11, 1'b0, 1'b0, 12'h012},
                             {2'b10, 1'b1, 1'b0, 12'h045},
                             {2'b01, 1'b0, 1'b1, 12'h078},
                             {2'b10, 1'b1, 1'b1, 12'h0F0},
                             16'h0000};
    for (int i = 0; i < 5; i++) begin
      y = ys[i];
      tick();
      n_checks++; if (mw !== emw[i]) begin n_fail++; $display("FAIL fetch_mw[%0d] got %h exp %h", i, mw, emw[i]); end
      n_checks++; if ({s, fe, pup, d} !== efl[i]) begin n_fail++; $display("FAIL fetch_fields[%0d] got %h exp %h", i, {s, fe, pup, d}, efl[i]); end
      n_checks++; if (run !== 1'b1 || zero !== 1'b1) begin n_fail++; $display("FAIL fetch_runzero[%0d] got %b%b exp 11", i, run, zero); end
`ifdef UCODE_PARITY_EN
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fetch_err[%0d] got %b exp 0", i, err); end
`endif
    end
  endtask

  task automatic test_hold();
    y = 12'h005;
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      we = (i == 0); wa = 12'h020; wd = 32'h0000_2222;
      y = 12'h006 + 12'(i);
      tick();
      n_checks++; if (mw !== 32'h123) begin n_fail++; $display("FAIL hold_mw[%0d] got %h exp 00000123", i, mw); end
      n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL hold_run[%0d] got %b exp 1", i, run); end
    end
    we = 1'b0; hold = 1'b0; y = 12'h008;
    tick();
    n_checks++; if (mw !== 32'hABC) begin n_fail++; $display("FAIL hold_resume got %h exp 00000abc", mw); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 12'h0A0; y = 12'h0A0; wd = 32'h5555_AAAA;
    tick();
    n_checks++; if (mw !== 32'h5555_AAAA) begin n_fail++; $display("FAIL bypass_mw got %h exp 5555aaaa", mw); end
    we = 1'b0; y = 12'h020;
    tick();
    n_checks++; if (mw !== 32'h2222) begin n_fail++; $display("FAIL write_in_hold got %h exp 00002222", mw); end
    y = 12'h0A0;
    tick();
    n_checks++; if (mw !== 32'h5555_AAAA) begin n_fail++; $display("FAIL bypass_stored got %h exp 5555aaaa", mw); end
  endtask

  task automatic test_reset_mid_write();
    we = 1'b1; wa = 12'h030; wd = 32'h0000_3333; y = 12'h006;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    tick();
    we = 1'b0; rst = 1'b0;
    tick();
    y = 12'h030;
    tick();
    n_checks++; if (mw !== 32'h0303) begin n_fail++; $display("FAIL reset_blocks_write got %h exp 00000303", mw); end
  endtask

  task automatic test_halt();
    y = 12'h300;
    tick();
    n_checks++; if (mw !== 32'h8000_0000) begin n_fail++; $display("FAIL halt_mw got %h exp 80000000", mw); end
    n_checks++; if (run !== 1'b0 || zero !== 1'b1) begin n_fail++; $display("FAIL halt_runzero got %b%b exp 01", run, zero); end
    y = 12'h301;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (mw !== 32'h8000_0000) begin n_fail++; $display("FAIL halt_held[%0d] got %h exp 80000000", i, mw); end
    end
    rst = 1'b1;
    #1;
    chk_idle_outputs("halt_reset");
    rst = 1'b0;
    tick();
    n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL halt_restart_run got %b exp 1", run); end
    y = 12'h005;
    tick();
    n_checks++; if (mw !== 32'h123) begin n_fail++; $display("FAIL halt_restart_mw got %h exp 00000123", mw); end
  endtask

`ifdef UCODE_PARITY_EN
  task automatic test_parity();
    we = 1'b1; wa = 12'h040; wd = 32'h0000_0041; y = 12'h005;
    tick();
    we = 1'b0;
    dut.u_store.mem_q[12'h040][32] = ~dut.u_store.mem_q[12'h040][32];
    y = 12'h040;
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL parity_err got %b exp 1", err); end
    n_checks++; if (mw !== 32'h0) begin n_fail++; $display("FAIL parity_mw got %h exp 00000000", mw); end
    n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL parity_run got %b exp 0", run); end
    y = 12'h005;
    tick();
    n_checks++; if (err !== 1'b1 || mw !== 32'h0) begin n_fail++; $display("FAIL parity_sticky got err=%b mw=%h exp err=1 mw=00000000", err, mw); end
    rst = 1'b1;
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL parity_clear got %b exp 0", err); end
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    preload();
    test_idle();
    test_fetch();
    test_hold();
    test_bypass();
    test_reset_mid_write();
    test_halt();
`ifdef UCODE_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
